store_unit: RTL and testbench

- Store-side counterpart of the load extraction path. Takes one store request (SB/SH/SW, byte address, rs2 data) and drives word-aligned memory write beats with per-byte enables and lane-shifted data.
- Splits misaligned stores that straddle a word boundary into two sequential beats.
- Sits between the execute/memory stage and the data memory write port.

---
 rtl/store_pkg.sv | 19 +
 rtl/store_lane_shift.sv | 42 ++++
 rtl/store_unit.sv | 136 +++++++++++++
 tb/tb_store_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_pkg.sv
// Shared store-path definitions: funct3 codes, byte masks, FSM states.
// Also imported by load-side decoding for the funct3 constants.
package store_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        BEAT0,
        BEAT1
    } state_t;

endpackage

// File: rtl/store_lane_shift.sv
// Positions store data and byte enables across a two-word window.
// Lanes outside the access width are forced to zero.
module store_lane_shift
    import store_pkg::*;
(
    input  logic [2:0]  type_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] data_i,
    output logic [63:0] data64_o,
    output logic [7:0]  mask8_o,
    output logic        split_o,
    output logic        illegal_o
);

    logic [3:0]  base;
    logic [31:0] wmask;

    always_comb begin
        base      = 4'b0000;
        wmask     = 32'h0000_0000;
        illegal_o = 1'b0;
        unique case (type_i)
            F3_SB: begin
                base  = MASK_B;
                wmask = 32'h0000_00FF;
            end
            F3_SH: begin
                base  = MASK_H;
                wmask = 32'h0000_FFFF;
            end
            F3_SW: begin
                base  = MASK_W;
                wmask = 32'hFFFF_FFFF;
            end
            default: illegal_o = 1'b1;
        endcase
        mask8_o  = {4'b0000, base} << offset_i;
        data64_o = {32'h0, data_i & wmask} << {offset_i, 3'b000};
        split_o  = |mask8_o[7:4];
    end

endmodule

// File: rtl/store_unit.sv
// Store request to memory write beats, splitting word-crossing stores.
// Illegal or disallowed requests are consumed and flagged via store_err.
module store_unit
    import store_pkg::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_data,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    output logic        store_done,
    output logic        store_err
);

    state_t      state_q, state_d;
    logic [31:0] addr0_q, data0_q, data1_q;
    logic [3:0]  be0_q, be1_q;
    logic        split_q;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [63:0] data64;
    logic [7:0]  mask8;
    logic        split, illegal, bad, accept;

    store_lane_shift u_shift (
        .type_i    (req_type),
        .offset_i  (req_addr[1:0]),
        .data_i    (req_data),
        .data64_o  (data64),
        .mask8_o   (mask8),
        .split_o   (split),
        .illegal_o (illegal)
    );

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;
    assign bad       = illegal || (split && !ALLOW_MISALIGNED);

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bad) err_d   = 1'b1;
                    else     state_d = BEAT0;
                end
            end
            BEAT0: begin
                if (mem_ack) begin
                    if (split_q) begin
                        state_d = BEAT1;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            BEAT1: begin
                if (mem_ack) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Beat registers load only on a legal accept, never while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr0_q <= 32'h0;
            data0_q <= 32'h0;
            data1_q <= 32'h0;
            be0_q   <= 4'h0;
            be1_q   <= 4'h0;
            split_q <= 1'b0;
        end else if (accept && !bad) begin
            addr0_q <= {req_addr[31:2], 2'b00};
            data0_q <= data64[31:0];
            data1_q <= data64[63:32];
            be0_q   <= mask8[3:0];
            be1_q   <= mask8[7:4];
            split_q <= split;
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_be    = 4'h0;
        unique case (state_q)
            BEAT0: begin
                mem_we    = 1'b1;
                mem_addr  = addr0_q;
                mem_wdata = data0_q;
                mem_be    = be0_q;
            end
            BEAT1: begin
                mem_we    = 1'b1;
                mem_addr  = addr0_q + 32'd4;
                mem_wdata = data1_q;
                mem_be    = be1_q;
            end
            default: ;
        endcase
    end

    assign store_done = done_q;
    assign store_err  = err_q;

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit: vector table plus corner sequences.
// A second instance checks the ALLOW_MISALIGNED=0 behaviour.
module tb_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_valid1;
    logic [31:0] req_addr, req_data;
    logic [2:0]  req_type;
    logic        mem_ack;

    logic        req_ready, mem_we, store_done, store_err;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    logic        req_ready1, mem_we1, store_done1, store_err1;
    logic [31:0] mem_addr1, mem_wdata1;
    logic [3:0]  mem_be1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    store_unit #(.ALLOW_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_type(req_type), .req_data(req_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack),
        .store_done(store_done), .store_err(store_err)
    );

    store_unit #(.ALLOW_MISALIGNED(1'b0)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1),
        .req_addr(req_addr), .req_type(req_type), .req_data(req_data),
        .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_be(mem_be1), .mem_ack(mem_ack),
        .store_done(store_done1), .store_err(store_err1)
    );

    typedef struct {
        logic [2:0]  typ;
        logic [31:0] addr;
        logic [31:0] data;
        int          nb;
        logic [31:0] a0;
        logic [3:0]  be0;
        logic [31:0] d0;
        logic [31:0] a1;
        logic [3:0]  be1;
        logic [31:0] d1;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_beat(input string nm, input logic [31:0] a,
                            input logic [3:0] be, input logic [31:0] d);
        chk({nm, " we"}, {31'b0, mem_we}, 32'd1);
        chk({nm, " addr"}, mem_addr, a);
        chk({nm, " be"}, {28'b0, mem_be}, {28'b0, be});
        chk({nm, " wdata"}, mem_wdata, d);
        chk({nm, " ready"}, {31'b0, req_ready}, 32'd0);
        chk({nm, " done"}, {31'b0, store_done}, 32'd0);
    endtask

    task automatic do_store(input vec_t v, input int dly, input string nm);
        logic [31:0] a[2];
        logic [3:0]  be[2];
        logic [31:0] d[2];
        a[0] = v.a0; be[0] = v.be0; d[0] = v.d0;
        a[1] = v.a1; be[1] = v.be1; d[1] = v.d1;
        @(negedge clk);
        req_valid = 1'b1;
        req_type  = v.typ;
        req_addr  = v.addr;
        req_data  = v.data;
        chk({nm, " ready idle"}, {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        // Garbage request while busy must be ignored entirely.
        req_type = 3'b010;
        req_addr = 32'h0;
        req_data = 32'hFFFF_FFFF;
        for (int b = 0; b < v.nb; b++) begin
            for (int w = 0; w < dly; w++) begin
                @(negedge clk);
                chk_beat($sformatf("%s b%0d wait%0d", nm, b, w),
                         a[b], be[b], d[b]);
                @(posedge clk);
                #1;
            end
            mem_ack = 1'b1;
            @(negedge clk);
            chk_beat($sformatf("%s b%0d ack", nm, b), a[b], be[b], d[b]);
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (b == v.nb - 1) req_valid = 1'b0;
        end
        @(negedge clk);
        chk({nm, " done"}, {31'b0, store_done}, 32'd1);
        chk({nm, " we off"}, {31'b0, mem_we}, 32'd0);
        chk({nm, " ready back"}, {31'b0, req_ready}, 32'd1);
        chk({nm, " no err"}, {31'b0, store_err}, 32'd0);
        @(negedge clk);
        chk({nm, " done pulse"}, {31'b0, store_done}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{3'b010, 32'h100, 32'hDEADBEEF, 1,
                    32'h100, 4'hF, 32'hDEADBEEF, 32'h0, 4'h0, 32'h0};
        vecs[1] = '{3'b000, 32'h103, 32'hFFFFFFAB, 1,
                    32'h100, 4'h8, 32'hAB000000, 32'h0, 4'h0, 32'h0};
        vecs[2] = '{3'b001, 32'h203, 32'h00001234, 2,
                    32'h200, 4'h8, 32'h34000000, 32'h204, 4'h1, 32'h12};
        vecs[3] = '{3'b010, 32'hFFFFFFFE, 32'h11223344, 2,
                    32'hFFFFFFFC, 4'hC, 32'h33440000,
                    32'h0, 4'h3, 32'h00001122};
        vecs[4] = '{3'b001, 32'h402, 32'hABCD5678, 1,
                    32'h400, 4'hC, 32'h56780000, 32'h0, 4'h0, 32'h0};
        vecs[5] = '{3'b000, 32'h501, 32'h123456C3, 1,
                    32'h500, 4'h2, 32'h0000C300, 32'h0, 4'h0, 32'h0};
        vecs[6] = '{3'b010, 32'h601, 32'hAABBCCDD, 2,
                    32'h600, 4'hE, 32'hBBCCDD00, 32'h604, 4'h1, 32'hAA};
        vecs[7] = '{3'b001, 32'h701, 32'hFFFF9ABC, 1,
                    32'h700, 4'h6, 32'h009ABC00, 32'h0, 4'h0, 32'h0};

        rst = 1'b1;
        req_valid = 1'b0;
        req_valid1 = 1'b0;
        req_addr = 32'h0;
        req_type = 3'b000;
        req_data = 32'h0;
        mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst ready", {31'b0, req_ready}, 32'd1);
        chk("rst we", {31'b0, mem_we}, 32'd0);
        chk("rst addr", mem_addr, 32'h0);
        chk("rst wdata", mem_wdata, 32'h0);
        chk("rst be", {28'b0, mem_be}, 32'h0);
        chk("rst done", {31'b0, store_done}, 32'd0);
        chk("rst err", {31'b0, store_err}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 8; i++)
            do_store(vecs[i], 0, $sformatf("vec%0d", i));

        do_store('{3'b010, 32'h102, 32'h11223344, 2,
                   32'h100, 4'hC, 32'h33440000,
                   32'h104, 4'h3, 32'h00001122}, 3, "slow");

        // Two illegal requests back to back.
        @(negedge clk);
        req_valid = 1'b1;
        req_type  = 3'b011;
        req_addr  = 32'h100;
        @(posedge clk);
        #1 req_type = 3'b111;
        @(negedge clk);
        chk("ill1 err", {31'b0, store_err}, 32'd1);
        chk("ill1 we", {31'b0, mem_we}, 32'd0);
        chk("ill1 ready", {31'b0, req_ready}, 32'd1);
        chk("ill1 done", {31'b0, store_done}, 32'd0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("ill2 err", {31'b0, store_err}, 32'd1);
        chk("ill2 we", {31'b0, mem_we}, 32'd0);
        @(negedge clk);
        chk("ill err pulse", {31'b0, store_err}, 32'd0);
        chk("ill no beat", {31'b0, mem_we}, 32'd0);

        // Reset while waiting in the second beat.
        @(negedge clk);
        req_valid = 1'b1;
        req_type  = 3'b001;
        req_addr  = 32'h203;
        req_data  = 32'h1234;
        @(posedge clk);
        #1 req_valid = 1'b0;
        mem_ack = 1'b1;
        @(posedge clk);
        #1 mem_ack = 1'b0;
        @(negedge clk);
        chk("mid b1 we", {31'b0, mem_we}, 32'd1);
        chk("mid b1 addr", mem_addr, 32'h204);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid rst we", {31'b0, mem_we}, 32'd0);
        chk("mid rst ready", {31'b0, req_ready}, 32'd1);
        chk("mid rst done", {31'b0, store_done}, 32'd0);
        chk("mid rst be", {28'b0, mem_be}, 32'h0);
        @(negedge clk);
        chk("mid rst done2", {31'b0, store_done}, 32'd0);

        // Ack while idle has no effect.
        mem_ack = 1'b1;
        @(posedge clk);
        #1 mem_ack = 1'b0;
        @(negedge clk);
        chk("idle ack we", {31'b0, mem_we}, 32'd0);
        chk("idle ack done", {31'b0, store_done}, 32'd0);
        chk("idle ack ready", {31'b0, req_ready}, 32'd1);

        do_store(vecs[0], 1, "post rst");

        // Misalignment disallowed on the second instance.
        @(negedge clk);
        req_valid1 = 1'b1;
        req_type   = 3'b010;
        req_addr   = 32'hFFFFFFFE;
        req_data   = 32'h11223344;
        @(posedge clk);
        #1 req_valid1 = 1'b0;
        @(negedge clk);
        chk("nomis err", {31'b0, store_err1}, 32'd1);
        chk("nomis we", {31'b0, mem_we1}, 32'd0);
        chk("nomis ready", {31'b0, req_ready1}, 32'd1);
        chk("nomis done", {31'b0, store_done1}, 32'd0);
        @(negedge clk);
        chk("nomis err pulse", {31'b0, store_err1}, 32'd0);
        chk("nomis we2", {31'b0, mem_we1}, 32'd0);

        @(negedge clk);
        req_valid1 = 1'b1;
        req_type   = 3'b000;
        req_addr   = 32'h103;
        req_data   = 32'hFFFFFFAB;
        @(posedge clk);
        #1 req_valid1 = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        chk("nomis sb we", {31'b0, mem_we1}, 32'd1);
        chk("nomis sb be", {28'b0, mem_be1}, 32'h8);
        chk("nomis sb wdata", mem_wdata1, 32'hAB000000);
        chk("nomis sb err", {31'b0, store_err1}, 32'd0);
        @(posedge clk);
        #1 mem_ack = 1'b0;
        @(negedge clk);
        chk("nomis sb done", {31'b0, store_done1}, 32'd1);
        chk("nomis sb we off", {31'b0, mem_we1}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
